// File: rtl/bus_arbiter.sv
// Two-port (fetch, load/store) round-robin arbiter and sequencer in front of the bus controller.
// Latency: request in IDLE -> bus access next cycle -> requester ack two cycles after bus ack; requesters wait (req held) until ack.
module bus_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_ack_o,
  output logic [DATA_W-1:0] f_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [1:0]        ls_size_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_ack_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              err_o,
  output logic              bus_access_o,
  output logic              bus_wr_en_o,
  output logic              bus_rd_en_o,
  output logic [1:0]        bus_size_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              busy_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic PORT_F  = 1'b0;
  localparam logic PORT_LS = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic              owner;
    logic              we;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } xfer_t;

  state_t            state_q, state_d;
  xfer_t             xfer_q, xfer_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              tmo_q, tmo_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              f_ack_q, f_ack_d;
  logic              ls_ack_q, ls_ack_d;
  logic              err_q, err_d;

  logic f_pend, ls_pend, pick_ls;

  // A port whose ack is on the wire this cycle is retiring its request, so it cannot win again.
  assign f_pend  = f_req_i  & ~f_ack_q;
  assign ls_pend = ls_req_i & ~ls_ack_q;
  assign pick_ls = ls_pend & (~f_pend | (last_grant_q == PORT_F));

  always_comb begin
    state_d      = state_q;
    xfer_d       = xfer_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    tmo_d        = tmo_q;
    rdata_d      = rdata_q;
    f_rdata_d    = f_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    f_ack_d      = 1'b0;
    ls_ack_d     = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (f_pend || ls_pend) begin
          if (pick_ls) begin
            xfer_d.owner = PORT_LS;
            xfer_d.we    = ls_we_i;
            xfer_d.size  = ls_size_i;
            xfer_d.addr  = ls_addr_i;
            xfer_d.wdata = ls_wdata_i;
          end else begin
            xfer_d.owner = PORT_F;
            xfer_d.we    = 1'b0;
            xfer_d.size  = 2'b10;
            xfer_d.addr  = f_addr_i;
            xfer_d.wdata = '0;
          end
          last_grant_d = pick_ls;
          cnt_d        = '0;
          tmo_d        = 1'b0;
          state_d      = BUSY;
        end
      end

      BUSY: begin
        // A bus ack on the expiry cycle still wins over the watchdog.
        if (bus_ack_i) begin
          rdata_d = xfer_q.we ? '0 : bus_rdata_i;
          tmo_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_MAX) begin
          rdata_d = '0;
          tmo_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (xfer_q.owner == PORT_LS) begin
          ls_ack_d   = 1'b1;
          ls_rdata_d = rdata_q;
        end else begin
          f_ack_d   = 1'b1;
          f_rdata_d = rdata_q;
        end
        err_d   = tmo_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      xfer_q       <= '0;
      cnt_q        <= '0;
      last_grant_q <= PORT_F;
      tmo_q        <= 1'b0;
      rdata_q      <= '0;
      f_rdata_q    <= '0;
      ls_rdata_q   <= '0;
      f_ack_q      <= 1'b0;
      ls_ack_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      xfer_q       <= xfer_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      tmo_q        <= tmo_d;
      rdata_q      <= rdata_d;
      f_rdata_q    <= f_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
      f_ack_q      <= f_ack_d;
      ls_ack_q     <= ls_ack_d;
      err_q        <= err_d;
    end
  end

  logic in_busy;
  assign in_busy = (state_q == BUSY);

  assign bus_access_o = in_busy;
  assign bus_wr_en_o  = in_busy & xfer_q.we;
  assign bus_rd_en_o  = in_busy & ~xfer_q.we;
  assign bus_size_o   = in_busy ? xfer_q.size  : 2'b00;
  assign bus_addr_o   = in_busy ? xfer_q.addr  : '0;
  assign bus_wdata_o  = in_busy ? xfer_q.wdata : '0;
  assign busy_o       = (state_q != IDLE);

  assign f_ack_o    = f_ack_q;
  assign ls_ack_o   = ls_ack_q;
  assign f_rdata_o  = f_rdata_q;
  assign ls_rdata_o = ls_rdata_q;
  assign err_o      = err_q;

endmodule
